alarm_bank: RTL and testbench

- Parametrised N-channel alarm engine for the clock/alarm top level.
- Each channel stores its own BCD hh:mm, so channels no longer share the time-set inputs.
- Compares the stored times against the running BCD time from the clock unit.
- Adds a bounded ring timeout, per-channel stop/snooze and a priority-encoded ring index.
- Runs on the 50 MHz system clock with a 1 Hz tick used as a clock enable; there is no divided clock domain.

---
 rtl/alarm_bank_pkg.sv | 30 +++
 rtl/alarm_bank_channel.sv | 107 ++++++++++
 rtl/alarm_bank.sv | 85 ++++++++
 tb/tb_alarm_bank.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_bank_pkg.sv
// Shared definitions for the alarm bank: channel FSM encoding, BCD digit
// limits and the channel-index width helper.
package alarm_bank_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnoozed = 2'd2
  } alarm_state_e;

  localparam logic [3:0] BcdDigitMax   = 4'd9;
  localparam logic [3:0] MinTensMax    = 4'd5;
  localparam logic [3:0] HrTensMax     = 4'd2;
  localparam logic [3:0] HrOnesMaxAt2x = 4'd3;  // hour ones limit when tens == 2

  // Channel index width; a single channel still needs a 1-bit select.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when hh:mm is a legal 24-hour BCD time.
  function automatic logic bcd_hm_valid(logic [3:0] hr_t, logic [3:0] hr_o,
                                        logic [3:0] min_t, logic [3:0] min_o);
    logic hr_ok;
    hr_ok = (hr_t < HrTensMax && hr_o <= BcdDigitMax) ||
            (hr_t == HrTensMax && hr_o <= HrOnesMaxAt2x);
    return hr_ok && (min_t <= MinTensMax) && (min_o <= BcdDigitMax);
  endfunction

endpackage

// File: rtl/alarm_bank_channel.sv
// One alarm channel: stored BCD hh:mm, match edge detector, IDLE/RINGING/
// SNOOZED FSM with saturating ring and snooze second counters.
// Snooze support is built only when ALARM_BANK_SNOOZE_EN is defined.
module alarm_bank_channel import alarm_bank_pkg::*; #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        sec_zero_i,
  input  logic [15:0] cur_hm_i,    // {hr_t, hr_o, min_t, min_o}
  input  logic        wr_i,        // validated write addressed to this channel
  input  logic [15:0] wr_hm_i,
  input  logic        arm_i,
  input  logic        stop_i,
  input  logic        snooze_i,
  output logic        ring_o
);

  localparam int unsigned RingCntW = (RING_SEC > 0) ? $clog2(RING_SEC + 1) : 1;
  localparam logic [RingCntW-1:0] RingLast = RingCntW'((RING_SEC > 0) ? RING_SEC - 1 : 0);

  alarm_state_e          state_q;
  logic [15:0]           stored_q;
  logic [RingCntW-1:0]   ring_cnt_q;
  logic                  match_q;
  logic                  ring_q;
  logic                  match;

`ifdef ALARM_BANK_SNOOZE_EN
  localparam int unsigned SnoozeTicks = SNOOZE_MIN * 60;
  localparam int unsigned SnzCntW = $clog2(SnoozeTicks + 1);
  localparam logic [SnzCntW-1:0] SnzLast = SnzCntW'(SnoozeTicks - 1);
  logic [SnzCntW-1:0] snz_cnt_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze_i;
`endif

  // Match is level-true for the whole 00 second; only its rising edge triggers.
  always_comb begin
    match = arm_i && sec_zero_i && (cur_hm_i == stored_q);
  end

  // Channel state, counters, stored time and registered ring output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      stored_q   <= '0;
      ring_cnt_q <= '0;
      match_q    <= 1'b0;
      ring_q     <= 1'b0;
`ifdef ALARM_BANK_SNOOZE_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      match_q <= match;
      ring_q  <= (state_q == StRinging);
      if (wr_i) stored_q <= wr_hm_i;
      if (!arm_i || wr_i) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (match && !match_q) begin
              state_q    <= StRinging;
              ring_cnt_q <= '0;
            end
          end
          StRinging: begin
            if (stop_i) begin
              state_q <= StIdle;
`ifdef ALARM_BANK_SNOOZE_EN
            end else if (snooze_i) begin
              state_q   <= StSnoozed;
              snz_cnt_q <= '0;
`endif
            end else if (tick_i && RING_SEC != 0) begin
              // Leave on the RING_SEC-th tick, so the counter never passes RingLast.
              if (ring_cnt_q == RingLast) state_q <= StIdle;
              else ring_cnt_q <= ring_cnt_q + 1'b1;
            end
          end
`ifdef ALARM_BANK_SNOOZE_EN
          StSnoozed: begin
            if (stop_i) begin
              state_q <= StIdle;
            end else if (tick_i) begin
              if (snz_cnt_q == SnzLast) begin
                state_q    <= StRinging;
                ring_cnt_q <= '0;
              end else begin
                snz_cnt_q <= snz_cnt_q + 1'b1;
              end
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/alarm_bank.sv
// N-channel alarm engine: write validation/decode, per-channel alarm
// instances and the ring_any / lowest-index ring encoder.
// Optional snooze support: define ALARM_BANK_SNOOZE_EN.
module alarm_bank import alarm_bank_pkg::*; #(
  parameter int unsigned NUM_ALARMS = 3,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  localparam int unsigned IDX_W     = idx_width(NUM_ALARMS)
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic [3:0]            cur_sec_t,
  input  logic [3:0]            cur_sec_o,
  input  logic [3:0]            cur_min_t,
  input  logic [3:0]            cur_min_o,
  input  logic [3:0]            cur_hr_t,
  input  logic [3:0]            cur_hr_o,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_sel,
  input  logic [3:0]            wr_min_t,
  input  logic [3:0]            wr_min_o,
  input  logic [3:0]            wr_hr_t,
  input  logic [3:0]            wr_hr_o,
  input  logic [NUM_ALARMS-1:0] arm,
  input  logic [NUM_ALARMS-1:0] stop,
  input  logic [NUM_ALARMS-1:0] snooze,
  output logic                  wr_err,
  output logic [NUM_ALARMS-1:0] ring,
  output logic                  ring_any,
  output logic [IDX_W-1:0]      ring_idx
);

  logic        wr_ok;
  logic        sec_zero;
  logic        wr_err_q;
  logic [15:0] cur_hm;
  logic [15:0] wr_hm;

  // Accept a write only for a legal time addressed to an existing channel.
  always_comb begin
    wr_ok    = wr_en && bcd_hm_valid(wr_hr_t, wr_hr_o, wr_min_t, wr_min_o) &&
               (32'(wr_sel) < NUM_ALARMS);
    sec_zero = (cur_sec_t == 4'd0) && (cur_sec_o == 4'd0);
    cur_hm   = {cur_hr_t, cur_hr_o, cur_min_t, cur_min_o};
    wr_hm    = {wr_hr_t, wr_hr_o, wr_min_t, wr_min_o};
  end

  // Rejected-write pulse, one cycle after the attempt.
  always_ff @(posedge clk_50MHz) begin
    if (reset) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_en && !wr_ok;
  end

  assign wr_err = wr_err_q;

  for (genvar n = 0; n < NUM_ALARMS; n++) begin : g_ch
    alarm_bank_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk_i      (clk_50MHz),
      .rst_i      (reset),
      .tick_i     (tick_1hz),
      .sec_zero_i (sec_zero),
      .cur_hm_i   (cur_hm),
      .wr_i       (wr_ok && (wr_sel == IDX_W'(n))),
      .wr_hm_i    (wr_hm),
      .arm_i      (arm[n]),
      .stop_i     (stop[n]),
      .snooze_i   (snooze[n]),
      .ring_o     (ring[n])
    );
  end

  // Lowest ringing channel wins; scan downward so the lowest index is written last.
  always_comb begin
    ring_idx = '0;
    ring_any = |ring;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ring[i]) ring_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model working in seconds/minutes.
module tb_alarm_bank;

  localparam int NA = 3;
  localparam int RS = 60;
  localparam int SM = 5;
  localparam int IW = 2;
`ifdef ALARM_BANK_SNOOZE_EN
  localparam bit SnzEn = 1'b1;
`else
  localparam bit SnzEn = 1'b0;
`endif

  logic          clk_50MHz = 1'b0;
  logic          reset, tick_1hz, wr_en;
  logic [3:0]    cur_sec_t, cur_sec_o, cur_min_t, cur_min_o, cur_hr_t, cur_hr_o;
  logic [IW-1:0] wr_sel;
  logic [3:0]    wr_min_t, wr_min_o, wr_hr_t, wr_hr_o;
  logic [NA-1:0] arm, stop, snooze;
  logic          wr_err, ring_any;
  logic [NA-1:0] ring;
  logic [IW-1:0] ring_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int now_s   = 0;  // running time, seconds of day

  always #10 clk_50MHz = ~clk_50MHz;

  always_comb begin
    cur_hr_t  = 4'((now_s / 3600) / 10);
    cur_hr_o  = 4'((now_s / 3600) % 10);
    cur_min_t = 4'(((now_s / 60) % 60) / 10);
    cur_min_o = 4'(((now_s / 60) % 60) % 10);
    cur_sec_t = 4'((now_s % 60) / 10);
    cur_sec_o = 4'((now_s % 60) % 10);
  end

  alarm_bank #(
    .NUM_ALARMS (NA),
    .RING_SEC   (RS),
    .SNOOZE_MIN (SM)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .cur_sec_t (cur_sec_t),
    .cur_sec_o (cur_sec_o),
    .cur_min_t (cur_min_t),
    .cur_min_o (cur_min_o),
    .cur_hr_t  (cur_hr_t),
    .cur_hr_o  (cur_hr_o),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_min_t  (wr_min_t),
    .wr_min_o  (wr_min_o),
    .wr_hr_t   (wr_hr_t),
    .wr_hr_o   (wr_hr_o),
    .arm       (arm),
    .stop      (stop),
    .snooze    (snooze),
    .wr_err    (wr_err),
    .ring      (ring),
    .ring_any  (ring_any),
    .ring_idx  (ring_idx)
  );

  // Model: mode 0 idle, 1 ringing, 2 snoozed; stored time as minute of day.
  int m_mode[NA];
  int m_alarm_min[NA];
  int m_rang[NA];
  int m_snoozed[NA];
  bit m_prev_match[NA];
  bit m_ring[NA];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t now_s=%0d", tag, got, exp, $time, now_s);
    end
  endtask

  task automatic model_update();
    bit valid, match;
    int hr, mn;
    hr    = int'(wr_hr_t) * 10 + int'(wr_hr_o);
    mn    = int'(wr_min_t) * 10 + int'(wr_min_o);
    valid = wr_en && wr_min_o <= 9 && wr_min_t <= 5 && wr_hr_o <= 9 && hr <= 23 &&
            int'(wr_sel) < NA;
    if (reset) begin
      m_err = 1'b0;
      for (int c = 0; c < NA; c++) begin
        m_mode[c] = 0; m_alarm_min[c] = 0; m_rang[c] = 0; m_snoozed[c] = 0;
        m_prev_match[c] = 1'b0; m_ring[c] = 1'b0;
      end
    end else begin
      m_err = wr_en && !valid;
      for (int c = 0; c < NA; c++) begin
        bit hit, rise;
        match = arm[c] && (now_s % 60 == 0) && (now_s / 60 == m_alarm_min[c]);
        rise  = match && !m_prev_match[c];
        hit   = valid && int'(wr_sel) == c;
        m_ring[c]       = (m_mode[c] == 1);
        m_prev_match[c] = match;
        if (hit) m_alarm_min[c] = hr * 60 + mn;
        if (!arm[c] || hit) m_mode[c] = 0;
        else if (m_mode[c] == 1) begin
          if (stop[c]) m_mode[c] = 0;
          else if (SnzEn && snooze[c]) begin m_mode[c] = 2; m_snoozed[c] = 0; end
          else if (tick_1hz && RS > 0) begin
            m_rang[c]++;
            if (m_rang[c] >= RS) m_mode[c] = 0;
          end
        end else if (m_mode[c] == 2) begin
          if (stop[c]) m_mode[c] = 0;
          else if (tick_1hz) begin
            m_snoozed[c]++;
            if (m_snoozed[c] >= SM * 60) begin m_mode[c] = 1; m_rang[c] = 0; end
          end
        end else if (rise) begin
          m_mode[c] = 1; m_rang[c] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [NA-1:0] exp_ring;
    logic [IW-1:0] exp_idx;
    @(posedge clk_50MHz);
    model_update();
    @(negedge clk_50MHz);
    exp_ring = '0;
    exp_idx  = '0;
    for (int c = NA - 1; c >= 0; c--) begin
      exp_ring[c] = m_ring[c];
      if (m_ring[c]) exp_idx = IW'(c);
    end
    check("ring", 32'(ring), 32'(exp_ring));
    check("ring_any", 32'(ring_any), 32'(|exp_ring));
    check("ring_idx", 32'(ring_idx), 32'(exp_idx));
    check("wr_err", 32'(wr_err), 32'(m_err));
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic tick_sec();
    tick_1hz = 1'b1;
    cycle();
    tick_1hz = 1'b0;
    now_s = (now_s + 1) % 86400;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_sec();
  endtask

  task automatic do_write(input int sel, input int ht, input int ho, input int mt, input int mo);
    wr_en = 1'b1; wr_sel = IW'(sel);
    wr_hr_t = 4'(ht); wr_hr_o = 4'(ho); wr_min_t = 4'(mt); wr_min_o = 4'(mo);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic pulse_stop(input int c);
    stop[c] = 1'b1; cycle(); stop = '0;
  endtask

  task automatic pulse_snooze(input int c);
    snooze[c] = 1'b1; cycle(); snooze = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cycles(2); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; wr_en = 1'b0; wr_sel = '0;
    wr_min_t = '0; wr_min_o = '0; wr_hr_t = '0; wr_hr_o = '0;
    arm = '0; stop = '0; snooze = '0;
    now_s = 3600;
    for (int c = 0; c < NA; c++) begin
      m_mode[c] = 0; m_alarm_min[c] = 0; m_rang[c] = 0; m_snoozed[c] = 0;
      m_prev_match[c] = 1'b0; m_ring[c] = 1'b0;
    end
    m_err = 1'b0;

    // Reset state
    cycles(2);
    reset = 1'b0;
    cycle();
    check("reset_ring", 32'(ring), 32'd0);
    check("reset_idx", 32'(ring_idx), 32'd0);

    // Basic match at 07:30:00 and bounded ring
    do_write(0, 0, 7, 3, 0);
    arm = 3'b001;
    now_s = 7 * 3600 + 29 * 60 + 59;
    tick_sec();
    cycles(2);
    check("match_ring0", 32'(ring[0]), 32'd1);
    check("match_any", 32'(ring_any), 32'd1);
    ticks(RS - 1);
    cycles(2);
    check("timeout_still_on", 32'(ring[0]), 32'd1);
    tick_sec();
    cycles(2);
    check("timeout_off", 32'(ring[0]), 32'd0);
    // Next day re-ring, then stop
    now_s = 7 * 3600 + 29 * 60 + 58;
    ticks(2);
    cycles(2);
    check("next_day_ring", 32'(ring[0]), 32'd1);
    pulse_stop(0);
    cycles(2);
    check("stop_off", 32'(ring[0]), 32'd0);

    // Snooze on channel 1
    do_write(1, 0, 8, 0, 0);
    arm = 3'b011;
    now_s = 7 * 3600 + 59 * 60 + 59;
    tick_sec();
    cycles(2);
    check("ch1_ring", 32'(ring[1]), 32'd1);
    pulse_snooze(1);
    cycles(2);
    check("snooze_effect", 32'(ring[1]), SnzEn ? 32'd0 : 32'd1);
    ticks(SM * 60);
    cycles(2);
    check("snooze_reringing", 32'(ring[1]), SnzEn ? 32'd1 : 32'd0);
    pulse_snooze(1);
    pulse_stop(1);
    ticks(SM * 60 + 5);
    check("snoozed_stop", 32'(ring[1]), 32'd0);

    // Two channels at 12:00, priority index
    do_write(0, 1, 2, 0, 0);
    do_write(2, 1, 2, 0, 0);
    arm = 3'b101;
    now_s = 11 * 3600 + 59 * 60 + 59;
    tick_sec();
    cycles(2);
    check("both_ring", 32'(ring), 32'b101);
    check("idx_low", 32'(ring_idx), 32'd0);
    pulse_stop(0);
    cycles(2);
    check("idx_after_stop", 32'(ring_idx), 32'd2);
    pulse_stop(2);

    // Rejected writes leave stored times intact
    do_write(0, 2, 4, 0, 0);
    check("err_hr24", 32'(wr_err), 32'd1);
    do_write(1, 0, 7, 6, 0);
    check("err_min60", 32'(wr_err), 32'd1);
    do_write(3, 0, 1, 0, 0);
    check("err_sel3", 32'(wr_err), 32'd1);
    cycle();
    check("err_clear", 32'(wr_err), 32'd0);
    arm = 3'b001;
    now_s = 12 * 3600 + 59 * 60 * 24;  // far away, then come back to 12:00
    now_s = 11 * 3600 + 59 * 60 + 59 + 86400 - 86400;
    cycles(70);  // let the previous second pass
    tick_sec();
    cycles(2);
    check("stored_kept", 32'(ring[0]), 32'd1);

    // Mid-ring interruptions: arm low, write, reset
    arm = 3'b000;
    cycles(2);
    check("arm_low_off", 32'(ring[0]), 32'd0);
    do_write(2, 1, 3, 0, 0);
    arm = 3'b100;
    now_s = 12 * 3600 + 59 * 60 + 59;
    tick_sec();
    cycles(2);
    check("ch2_ring", 32'(ring[2]), 32'd1);
    do_write(2, 1, 3, 0, 0);
    cycles(1);
    check("write_off", 32'(ring[2]), 32'd0);
    now_s = 12 * 3600 + 59 * 60 + 59;
    cycles(2);
    tick_sec();
    cycles(2);
    check("ch2_ring_again", 32'(ring[2]), 32'd1);
    do_reset();
    cycles(1);
    check("reset_off", 32'(ring), 32'd0);
    arm = 3'b001;
    now_s = 23 * 3600 + 59 * 60 + 59;
    tick_sec();
    cycles(2);
    check("reset_stored_0000", 32'(ring[0]), 32'd1);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(999));
      if (r < 5) arm[$urandom_range(NA - 1)] ^= 1'b1;
      if ($urandom_range(99) < 2) stop[$urandom_range(NA - 1)] = 1'b1;
      if ($urandom_range(99) < 3) snooze[$urandom_range(NA - 1)] = 1'b1;
      if ($urandom_range(99) < 2) begin
        int wm;
        wr_en  = 1'b1;
        wr_sel = IW'($urandom_range(3));
        if ($urandom_range(9) < 7) begin
          wm = (now_s / 60 + int'($urandom_range(2))) % 1440;
          wr_hr_t = 4'((wm / 60) / 10); wr_hr_o = 4'((wm / 60) % 10);
          wr_min_t = 4'((wm % 60) / 10); wr_min_o = 4'((wm % 60) % 10);
        end else begin
          wr_hr_t = 4'($urandom_range(15)); wr_hr_o = 4'($urandom_range(15));
          wr_min_t = 4'($urandom_range(15)); wr_min_o = 4'($urandom_range(15));
        end
      end
      if (r >= 990) now_s = (m_alarm_min[$urandom_range(NA - 1)] * 60 + 86400 - 1 -
                             int'($urandom_range(2))) % 86400;
      reset = (r == 500);
      tick_1hz = ($urandom_range(99) < 30);
      cycle();
      if (tick_1hz) now_s = (now_s + 1) % 86400;
      tick_1hz = 1'b0; wr_en = 1'b0; stop = '0; snooze = '0; reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
